// File: rtl/ddfs_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ddfs_pkg
//  Description : Shared constants for the DDFS waveform generator, plus the
//                constant function that builds the quarter-wave sine table.
//  Revision    : 1.0 - initial release
// ============================================================================
package ddfs_pkg;

    // wave_sel encodings
    localparam logic [1:0] WAVE_SINE   = 2'd0;
    localparam logic [1:0] WAVE_SQUARE = 2'd1;
    localparam logic [1:0] WAVE_SAW    = 2'd2;
    localparam logic [1:0] WAVE_TRI    = 2'd3;

    // DAC code constants (offset binary)
    localparam int         DATA_W  = 12;
    localparam logic [11:0] DAC_MID = 12'h800;
    localparam logic [11:0] DAC_MAX = 12'hFFF;

    // round(2047 * sin(pi/2 * (idx + 0.5) / 2^aw)), evaluated at elaboration.
    // Fixed-point Taylor series in Q30; the angle never exceeds pi/2, so all
    // intermediate products stay inside a signed 64-bit range.
    function automatic logic [10:0] sine_quarter_value(input int idx, input int aw);
        longint half_pi_q30;
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint val;
        half_pi_q30 = 64'sd1686629713;
        x    = (half_pi_q30 * longint'(2 * idx + 1)) >>> (aw + 1);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k < 12; k++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1)));
            sum  = sum + term;
        end
        val = (64'sd2047 * sum + 64'sd536870912) >>> 30;
        if (val > 64'sd2047) val = 64'sd2047;
        if (val < 64'sd0)    val = 64'sd0;
        return 11'(val);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sine_quarter_lut.sv
`default_nettype none
// ============================================================================
//  Module      : sine_quarter_lut
//  Description : Quarter-wave sine ROM, 11-bit unsigned amplitude, registered
//                read (one cycle of latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module sine_quarter_lut
    import ddfs_pkg::*;
#(
    parameter int LUT_AW = 8
) (
    input  logic              clk_in,
    input  logic [LUT_AW-1:0] i_addr,
    output logic [10:0]       o_data
);

    localparam int c_DEPTH = 1 << LUT_AW;

    logic [10:0] w_rom [c_DEPTH];
    logic [10:0] r_data;

    // Table contents are elaboration-time constants
    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_rom
        localparam logic [10:0] c_ENTRY = sine_quarter_value(gi, LUT_AW);
        assign w_rom[gi] = c_ENTRY;
    end

    // Registered read so the ROM maps onto block memory
    always_ff @(posedge clk_in) begin
        r_data <= w_rom[i_addr];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/ddfs_wave_gen.sv
`default_nettype none
// ============================================================================
//  Module      : ddfs_wave_gen
//  Description : Direct digital frequency synthesiser. Each rising edge of the
//                divided sample clock advances a phase accumulator; the phase
//                is turned into a 12-bit offset-binary sine, square, sawtooth
//                or triangle sample and written to the DAC with a strobe.
//                Pipeline: tick -> capture -> fold -> LUT -> mux -> DAC reg.
//  Revision    : 1.0 - initial release
// ============================================================================
module ddfs_wave_gen
    import ddfs_pkg::*;
#(
    parameter int PHASE_W = 24,
    parameter int LUT_AW  = 8,
    parameter int DATA_W  = 12
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic               samp_clk,
    input  logic [PHASE_W-1:0] tune_word,
    input  logic [1:0]         wave_sel,
    output logic [DATA_W-1:0]  dac_data,
    output logic               dac_wr
);

    // Phase bits carried down the pipe: enough for the 12-bit sawtooth and
    // for quadrant + LUT address, whichever is wider.
    localparam int c_CAP_W = (LUT_AW + 2 > 12) ? (LUT_AW + 2) : 12;

    // Synchroniser / edge detector
    logic r_s1;
    logic r_s2;
    logic r_s3;
    logic w_tick;

    // Accumulator and C1 capture stage
    logic [PHASE_W-1:0] r_acc;
    logic               r_c1_vld;
    logic [1:0]         r_c1_wave;
    logic [c_CAP_W-1:0] r_c1_phase;

    // C2 fold stage
    logic [1:0]         w_quad;
    logic [LUT_AW-1:0]  w_x;
    logic [LUT_AW-1:0]  w_addr;
    logic               r_c2_vld;
    logic [1:0]         r_c2_wave;
    logic [11:0]        r_c2_top;
    logic [LUT_AW-1:0]  r_c2_addr;

    // C3 LUT stage
    logic               r_c3_vld;
    logic [1:0]         r_c3_wave;
    logic [11:0]        r_c3_top;
    logic [10:0]        w_lut;
    logic [10:0]        w_tri;
    logic [DATA_W-1:0]  w_sample;

    // DAC output stage
    logic [DATA_W-1:0]  r_dac_data;
    logic               r_dac_wr;

    // Two-flop synchroniser plus history flop; reset high so a sample clock
    // that is already high coming out of reset is not mistaken for an edge
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= samp_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_tick = r_s2 & ~r_s3;

    // Advance the phase and capture phase / wave select for this sample
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_acc      <= '0;
            r_c1_vld   <= 1'b0;
            r_c1_wave  <= WAVE_SINE;
            r_c1_phase <= '0;
        end else begin
            r_c1_vld <= w_tick;
            if (w_tick) begin
                r_acc      <= r_acc + tune_word;
                r_c1_wave  <= wave_sel;
                r_c1_phase <= r_acc[PHASE_W-1 -: c_CAP_W];
            end
        end
    end

    // Odd quadrants walk the quarter-wave table backwards
    assign w_quad = r_c1_phase[c_CAP_W-1 -: 2];
    assign w_x    = r_c1_phase[c_CAP_W-3 -: LUT_AW];
    assign w_addr = w_quad[0] ? ~w_x : w_x;

    // Register the folded address alongside the sample's side data
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_c2_vld  <= 1'b0;
            r_c2_wave <= WAVE_SINE;
            r_c2_top  <= '0;
            r_c2_addr <= '0;
        end else begin
            r_c2_vld  <= r_c1_vld;
            r_c2_wave <= r_c1_wave;
            r_c2_top  <= r_c1_phase[c_CAP_W-1 -: 12];
            r_c2_addr <= w_addr;
        end
    end

    sine_quarter_lut #(
        .LUT_AW (LUT_AW)
    ) u_sine_lut (
        .clk_in (clk_in),
        .i_addr (r_c2_addr),
        .o_data (w_lut)
    );

    // Side data delayed to line up with the registered ROM output
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_c3_vld  <= 1'b0;
            r_c3_wave <= WAVE_SINE;
            r_c3_top  <= '0;
        end else begin
            r_c3_vld  <= r_c2_vld;
            r_c3_wave <= r_c2_wave;
            r_c3_top  <= r_c2_top;
        end
    end

    // Triangle folds about the half-cycle point
    assign w_tri = r_c3_top[10:0] ^ {11{r_c3_top[11]}};

    // Waveform select and offset-binary mapping
    always_comb begin
        w_sample = DAC_MID;
        case (r_c3_wave)
            WAVE_SINE:   w_sample = r_c3_top[11] ? (12'h7FF - {1'b0, w_lut})
                                                 : (DAC_MID + {1'b0, w_lut});
            WAVE_SQUARE: w_sample = r_c3_top[11] ? 12'h000 : DAC_MAX;
            WAVE_SAW:    w_sample = r_c3_top;
            WAVE_TRI:    w_sample = {w_tri, 1'b0};
            default:     w_sample = DAC_MID;
        endcase
    end

    // DAC register: data held between strobes, one strobe per sample
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_dac_data <= DAC_MID;
            r_dac_wr   <= 1'b0;
        end else begin
            r_dac_wr <= r_c3_vld;
            if (r_c3_vld) begin
                r_dac_data <= w_sample;
            end
        end
    end

    assign dac_data = r_dac_data;
    assign dac_wr   = r_dac_wr;

endmodule
`default_nettype wire
